// File: rtl/face_instr_seq.sv
// FACE instruction issuer.
// Walks a linear program held in a 1-cycle-latency BRAM and presents each word
// on instr for one cycle. After every systolic calc word it waits for FACE to
// raise and then drop busy, aborting on a missing ack or an over-long calc.

`ifndef SYSOPCODE
`define SYSOPCODE 7'b0001011
`endif
`ifndef systolic_calc_FUNC
`define systolic_calc_FUNC 3'b001
`endif

module face_instr_seq #(
  parameter int PROG_AW     = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PROG_AW-1:0] prog_base,
  input  logic [PROG_AW:0]   prog_len,
  output logic [PROG_AW-1:0] prog_addr,
  input  logic [31:0]        prog_rdata,
  output logic [31:0]        instr,
  input  logic               face_busy,
  output logic               seq_busy,
  output logic               done,
  output logic [1:0]         err,
  output logic [PROG_AW:0]   issued_cnt
);

  localparam logic [16:0]      TO_LAST = 17'(TIMEOUT_CYC - 1);
  localparam logic [PROG_AW:0] ONE     = 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    FINISH
  } state_t;

  state_t           state;
  logic [PROG_AW:0] remaining;  // words still to issue
  logic             ack_late;   // set on the first WAIT_ACK cycle without busy
  logic [16:0]      busy_cyc;   // cycles spent in WAIT_DONE for the current calc
  logic             is_calc;

  // The word arriving from BRAM is a systolic calc (decoded while in ISSUE).
  assign is_calc = (prog_rdata[6:0] == `SYSOPCODE) &&
                   (prog_rdata[9:7] == `systolic_calc_FUNC);

  // Sequencer FSM; every output is a register updated here.
  // NOTE: all state uses non-blocking assignments, and instr/done get a default
  // of 0 at the top of the clocked branch so they are pulses unless a state
  // explicitly drives them this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prog_addr  <= '0;
      instr      <= '0;
      seq_busy   <= 1'b0;
      done       <= 1'b0;
      err        <= 2'b00;
      issued_cnt <= '0;
      remaining  <= '0;
      ack_late   <= 1'b0;
      busy_cyc   <= '0;
    end else begin
      instr <= '0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            prog_addr  <= prog_base;
            remaining  <= prog_len;
            err        <= 2'b00;
            issued_cnt <= '0;
            seq_busy   <= 1'b1;
            // A zero-length program drops out of FETCH straight to FINISH.
            state      <= FETCH;
          end
        end

        FETCH: begin
          if (remaining == '0)
            state <= FINISH;
          else if (!face_busy)
            state <= ISSUE;
        end

        ISSUE: begin
          instr      <= prog_rdata;
          issued_cnt <= issued_cnt + 1'b1;
          prog_addr  <= prog_addr + 1'b1;
          remaining  <= remaining - 1'b1;
          if (is_calc) begin
            ack_late <= 1'b0;
            state    <= WAIT_ACK;
          end else if (remaining == ONE) begin
            state <= FINISH;
          end else begin
            state <= FETCH;
          end
        end

        WAIT_ACK: begin
          if (face_busy) begin
            busy_cyc <= '0;
            state    <= WAIT_DONE;
          end else if (ack_late) begin
            err   <= 2'b01;
            state <= FINISH;
          end else begin
            ack_late <= 1'b1;
          end
        end

        WAIT_DONE: begin
          if (!face_busy) begin
            state <= (remaining == '0) ? FINISH : FETCH;
          end else if (busy_cyc == TO_LAST) begin
            err   <= 2'b10;
            state <= FINISH;
          end else begin
            busy_cyc <= busy_cyc + 1'b1;
          end
        end

        FINISH: begin
          done     <= 1'b1;
          seq_busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
